// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I fetch-stage PC unit.
// - FSM state encoding (2-bit, legacy-compatible constants)
// - Sequential step sizes
// - Default reset vector
// - Target alignment helper
package rv32i_pkg;

  localparam logic [1:0] S_BOOT     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_MISALIGN = 2'd2;

  localparam int unsigned STEP_4 = 4;
  localparam int unsigned STEP_2 = 2;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // A target is misaligned when bit0 is set, or when bit1 is set and
  // compressed instructions are disabled (4-byte alignment required).
  function automatic logic is_misaligned(input logic [1:0] low, input logic c_en);
    return low[0] | (~c_en & low[1]);
  endfunction

endpackage

// File: rtl/pc_step_adder_rv32i.sv
// Combinational PC + step adder.
// Ports:
//   base   : address to advance
//   inst_c : instruction at base is compressed (step +2 when C_EN=1)
//   sum    : base + 2 or base + 4, wrapping modulo 2^XLEN
module pc_step_adder_rv32i
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int C_EN = 0
) (
  input  logic [XLEN-1:0] base,
  input  logic            inst_c,
  output logic [XLEN-1:0] sum
);

  logic [XLEN-1:0] step;

  // inst_c has no effect unless compressed support is built in.
  assign step = ((C_EN != 0) && inst_c) ? XLEN'(STEP_2) : XLEN'(STEP_4);
  assign sum  = base + step;

endmodule

// File: rtl/pc_unit_rv32i.sv
// Registered program counter for the head of the fetch stage.
// Ports:
//   clock, reset_n    : rising-edge clock, asynchronous active-low reset
//   stall             : hold PC this cycle
//   inst_c            : current instruction is compressed
//   redirect_valid/_target : branch/jump taken and its target
//   trap_valid/trap_vector : trap entry request and handler address
//   PC                : current fetch address
//   PCnext_seq        : PC + step, combinational (link-register value)
//   pc_valid          : PC is a legal fetch address this cycle
//   misalign          : misaligned-target exception pending
//   misalign_addr     : last offending redirect target
//   adv_count         : number of sequential advances since reset
//   state             : FSM state, exported for observation
//
// Request semantics: stall, redirect_valid and trap_valid are level
// requests sampled on every rising edge; there is no acceptance
// handshake. Any request sampled in S_RUN takes effect on that edge and
// is visible on PC one cycle later. Priority is trap > redirect > stall >
// sequential advance, so a flush always beats a stall.
module pc_unit_rv32i
  import rv32i_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int              C_EN         = 0,
  parameter int              CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             inst_c,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_vector,
  output logic [XLEN-1:0]  PC,
  output logic [XLEN-1:0]  PCnext_seq,
  output logic             pc_valid,
  output logic             misalign,
  output logic [XLEN-1:0]  misalign_addr,
  output logic [CNT_W-1:0] adv_count,
  output logic [1:0]       state
);

  logic target_bad;

  pc_step_adder_rv32i #(
    .XLEN (XLEN),
    .C_EN (C_EN)
  ) u_step (
    .base   (PC),
    .inst_c (inst_c),
    .sum    (PCnext_seq)
  );

  assign target_bad = is_misaligned(redirect_target[1:0], C_EN != 0);

  // Both flags follow the state register directly, so they return to
  // their reset values as soon as reset_n falls.
  assign pc_valid = (state == S_RUN);
  assign misalign = (state == S_MISALIGN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_BOOT;
      PC            <= RESET_VECTOR;
      misalign_addr <= '0;
      adv_count     <= '0;
    end else begin
      case (state)
        // One settling cycle after reset; every input is ignored.
        S_BOOT: state <= S_RUN;

        S_RUN: begin
          if (trap_valid) begin
            // Trap wins outright; the redirect target is not checked.
            PC <= trap_vector;
          end else if (redirect_valid) begin
            if (target_bad) begin
              misalign_addr <= redirect_target;
              state         <= S_MISALIGN;
            end else begin
              PC <= redirect_target;
            end
          end else if (!stall) begin
            PC        <= PCnext_seq;
            adv_count <= adv_count + CNT_W'(1);
          end
        end

        // Only a trap leaves this state; misalign_addr is kept.
        S_MISALIGN: begin
          if (trap_valid) begin
            PC    <= trap_vector;
            state <= S_RUN;
          end
        end

        default: state <= S_BOOT;
      endcase
    end
  end

endmodule
